adc_serial_responder: RTL and testbench

//  Slave end of the ADC serial read link: emulates the 16-bit serial ADC the

---
 rtl/adc_serial_responder_if.sv | 24 ++
 rtl/adc_serial_responder.sv | 152 +++++++++++++++
 tb/tb_adc_serial_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_responder_if.sv
// Bus bundle between the ADC-link initiator/feeder (master) and the
// serial responder (slave): chip select, serial data and sample handshake.
interface adc_serial_responder_if #(
  parameter int DATA_BITS = 12
);
  logic                 csIn;
  logic                 adcData;
  logic [DATA_BITS-1:0] inData;
  logic                 inValid;
  logic                 inReady;
  logic                 frameDone;
  logic                 underrun;
  logic                 abort;

  modport master (
    output csIn, inData, inValid,
    input  adcData, inReady, frameDone, underrun, abort
  );

  modport slave (
    input  csIn, inData, inValid,
    output adcData, inReady, frameDone, underrun, abort
  );
endinterface

// File: rtl/adc_serial_responder.sv
// Serial ADC emulator: per chip-select frame sends LEAD_ZEROS zeros then one
// sample from a 1-entry valid/ready holding register. Optional: ADC_RAMP_EN.
module adc_serial_responder #(
  parameter int DATA_BITS  = 12,
  parameter int LEAD_ZEROS = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  adc_serial_responder_if.slave  bus
);
  localparam int FRAME = LEAD_ZEROS + DATA_BITS;
  localparam int CW    = $clog2(FRAME + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DATA_BITS-1:0] word;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic [DATA_BITS-1:0] last_sample;
  logic                 adc_data_q;
  logic                 frame_done_q;
  logic                 underrun_q;
  logic                 abort_q;
`ifdef ADC_RAMP_EN
  logic [DATA_BITS-1:0] ramp;
`endif

  logic                 frame_start;
  logic                 consume;
  logic                 ready;
  logic                 load;
  logic [DATA_BITS-1:0] start_word;

  // Frame bit idx: leading zeros, then the sample in the configured order.
  function automatic logic frame_bit(input logic [DATA_BITS-1:0] w,
                                     input logic [CW-1:0]        idx);
    int j;
    frame_bit = 1'b0;
    if (int'(idx) >= LEAD_ZEROS && int'(idx) < FRAME) begin
      j = int'(idx) - LEAD_ZEROS;
      frame_bit = MSB_FIRST ? w[DATA_BITS-1-j] : w[j];
    end
  endfunction

  assign frame_start = (state == IDLE) && !bus.csIn;
  assign consume     = frame_start && hold_full;
  // A frame start frees the holding register in the same cycle, so a new
  // sample can land while the old one goes out.
  assign ready       = !hold_full || consume;
  assign load        = bus.inValid && ready;

  always_comb begin
    start_word = last_sample;
    if (hold_full) begin
      start_word = hold_data;
    end else begin
`ifdef ADC_RAMP_EN
      start_word = ramp;
`else
      start_word = last_sample;
`endif
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      word         <= '0;
      hold_data    <= '0;
      hold_full    <= 1'b0;
      last_sample  <= '0;
      adc_data_q   <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      abort_q      <= 1'b0;
`ifdef ADC_RAMP_EN
      ramp         <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      abort_q      <= 1'b0;

      if (load) begin
        hold_data <= bus.inData;
        hold_full <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          adc_data_q <= 1'b0;
          if (!bus.csIn) begin
            word        <= start_word;
            last_sample <= start_word;
            adc_data_q  <= frame_bit(start_word, '0);
            cnt         <= CW'(1);
            state       <= SHIFT;
            if (!hold_full) begin
              underrun_q <= 1'b1;
`ifdef ADC_RAMP_EN
              ramp       <= ramp + 1'b1;
`endif
            end
          end
        end

        SHIFT: begin
          if (bus.csIn) begin
            adc_data_q <= 1'b0;
            abort_q    <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
          end else if (cnt == CW'(FRAME)) begin
            adc_data_q   <= 1'b0;
            frame_done_q <= 1'b1;
            cnt          <= '0;
            state        <= DONE;
          end else begin
            adc_data_q <= frame_bit(word, cnt);
            cnt        <= cnt + 1'b1;
          end
        end

        DONE: begin
          adc_data_q <= 1'b0;
          if (bus.csIn) begin
            state <= IDLE;
          end
        end

        default: begin
          adc_data_q <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.adcData   = adc_data_q;
  assign bus.inReady   = ready;
  assign bus.frameDone = frame_done_q;
  assign bus.underrun  = underrun_q;
  assign bus.abort     = abort_q;
endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: scoreboard of expected serial bits,
// handshake and pulse checks on an MSB-first and an LSB-first instance.
module tb_adc_serial_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_serial_responder_if #(.DATA_BITS(12)) bus_a ();
  adc_serial_responder_if #(.DATA_BITS(12)) bus_b ();

  adc_serial_responder #(.DATA_BITS(12), .LEAD_ZEROS(4), .MSB_FIRST(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  adc_serial_responder #(.DATA_BITS(12), .LEAD_ZEROS(4), .MSB_FIRST(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic [11:0] last_m = 12'h000;
`ifdef ADC_RAMP_EN
  logic [11:0] ramp_m = 12'h000;
`endif
  bit   sel = 1'b0;

  logic o_data, o_ready, o_done, o_under, o_abort;
  always_comb begin
    o_data  = sel ? bus_b.adcData   : bus_a.adcData;
    o_ready = sel ? bus_b.inReady   : bus_a.inReady;
    o_done  = sel ? bus_b.frameDone : bus_a.frameDone;
    o_under = sel ? bus_b.underrun  : bus_a.underrun;
    o_abort = sel ? bus_b.abort     : bus_a.abort;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cs(input logic v);
    if (sel) bus_b.csIn = v;
    else     bus_a.csIn = v;
  endtask

  task automatic drive_in(input logic v, input logic [11:0] d);
    if (sel) begin bus_b.inValid = v; bus_b.inData = d; end
    else     begin bus_a.inValid = v; bus_a.inData = d; end
  endtask

  // Expected sample for a frame that starts with the holding register empty.
  function automatic logic [11:0] fill_word();
`ifdef ADC_RAMP_EN
    fill_word = ramp_m;
    ramp_m    = ramp_m + 12'h001;
`else
    fill_word = last_m;
`endif
  endfunction

  task automatic push_frame(input logic [11:0] w, input bit msb);
    for (int i = 0; i < 16; i++) begin
      if (i < 4)    exp_q.push_back(1'b0);
      else if (msb) exp_q.push_back(w[11-(i-4)]);
      else          exp_q.push_back(w[i-4]);
    end
  endtask

  // Entered just after a negedge; loads one sample through the handshake.
  task automatic load(input logic [11:0] v, input bit exp_ready);
    drive_in(1'b1, v);
    check("load_ready", o_ready, exp_ready);
    @(negedge clk);
    drive_in(1'b0, 12'h000);
  endtask

  // stop_kind: 0 full frame, 1 csIn rises after stop_at bits, 2 rst after stop_at bits.
  task automatic frame(input logic [11:0] w, input bit under, input bit msb,
                       input int stop_at, input int stop_kind,
                       input bit co_load, input logic [11:0] co_val);
    push_frame(w, msb);
    last_m = w;
    drive_cs(1'b0);
    if (co_load) drive_in(1'b1, co_val);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) begin
        drive_in(1'b0, 12'h000);
        check("underrun", o_under, under);
        check("ready_after_start", o_ready, !co_load);
      end else begin
        check("underrun_quiet", o_under, 1'b0);
      end
      if (c <= 16) begin
        check($sformatf("bit%0d", c - 1), o_data, exp_q.pop_front());
        check("done_early", o_done, 1'b0);
      end else begin
        check("frame_done", o_done, 1'b1);
        check("data_after_frame", o_data, 1'b0);
      end
      if (stop_kind != 0 && c == stop_at) begin
        if (stop_kind == 1) begin
          drive_cs(1'b1);
          @(negedge clk);
          check("abort", o_abort, 1'b1);
          check("abort_data", o_data, 1'b0);
          check("abort_no_done", o_done, 1'b0);
        end else begin
          rst = 1'b1;
          drive_cs(1'b1);
          @(negedge clk);
          check("rst_data", o_data, 1'b0);
          check("rst_ready", o_ready, 1'b1);
          check("rst_done", o_done, 1'b0);
          check("rst_underrun", o_under, 1'b0);
          check("rst_abort", o_abort, 1'b0);
          rst = 1'b0;
          last_m = 12'h000;
`ifdef ADC_RAMP_EN
          ramp_m = 12'h000;
`endif
        end
        exp_q.delete();
        @(negedge clk);
        return;
      end
    end
    drive_cs(1'b1);
    @(negedge clk);
    check("done_one_cycle", o_done, 1'b0);
    check("no_abort", o_abort, 1'b0);
    check("idle_data", o_data, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.csIn = 1'b1; bus_a.inValid = 1'b0; bus_a.inData = 12'h000;
    bus_b.csIn = 1'b1; bus_b.inValid = 1'b0; bus_b.inData = 12'h000;
    repeat (2) @(negedge clk);
    check("reset_data", o_data, 1'b0);
    check("reset_ready", o_ready, 1'b1);
    check("reset_done", o_done, 1'b0);
    check("reset_underrun", o_under, 1'b0);
    check("reset_abort", o_abort, 1'b0);
    check("reset_ready_b", bus_b.inReady, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Underrun straight after reset, twice (ramp build advances 0 -> 1).
    frame(fill_word(), 1'b1, 1'b1, 0, 0, 1'b0, 12'h000);
    frame(fill_word(), 1'b1, 1'b1, 0, 0, 1'b0, 12'h000);

    // Normal loaded frame.
    load(12'hA5C, 1'b1);
    frame(12'hA5C, 1'b0, 1'b1, 0, 0, 1'b0, 12'h000);

    // Abort after 8 bits, then an underrun frame repeats the aborted sample.
    load(12'h001, 1'b1);
    frame(12'h001, 1'b0, 1'b1, 8, 1, 1'b0, 12'h000);
    frame(fill_word(), 1'b1, 1'b1, 0, 0, 1'b0, 12'h000);

    // Load and consume in the same cycle.
    load(12'h456, 1'b1);
    frame(12'h456, 1'b0, 1'b1, 0, 0, 1'b1, 12'h123);
    frame(12'h123, 1'b0, 1'b1, 0, 0, 1'b0, 12'h000);

    // Data offered while the holding register is full is ignored.
    load(12'h0F0, 1'b1);
    load(12'h0AA, 1'b0);
    frame(12'h0F0, 1'b0, 1'b1, 0, 0, 1'b0, 12'h000);
    frame(fill_word(), 1'b1, 1'b1, 0, 0, 1'b0, 12'h000);

    // Reset mid-frame, then an underrun frame carries the reset value.
    load(12'h3C3, 1'b1);
    frame(12'h3C3, 1'b0, 1'b1, 9, 2, 1'b0, 12'h000);
    frame(fill_word(), 1'b1, 1'b1, 0, 0, 1'b0, 12'h000);

    // LSB-first instance.
    sel = 1'b1;
    @(negedge clk);
    load(12'h801, 1'b1);
    frame(12'h801, 1'b0, 1'b0, 0, 0, 1'b0, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
